// File: rtl/odesa_pkg.sv
// Shared definitions for the ODESA supervised layer.
//   state_e      : classification FSM states
//   clog2        : ceiling log2 usable in parameter expressions
//   score_width  : width of a weight*trace dot product over all channels
//   trace_max    : value a trace is loaded with on an event
package odesa_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StScore,
    StSelect,
    StLearn
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Two operand widths for the product, plus carry room for the channel sum.
  function automatic int unsigned score_width(input int unsigned width, input int unsigned n_in);
    return 2 * width + clog2(n_in);
  endfunction

  function automatic int unsigned trace_max(input int unsigned width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/odesa_trace.sv
// One decaying event trace.
//   clk, rst_n : clock, asynchronous active-low reset
//   evt        : event pulse; trace loads its maximum on the next cycle
//   trace      : current trace value, decrements every 2^P_DECAY_SHIFT clocks, floors at 0
module odesa_trace
  import odesa_pkg::*;
#(
  parameter int unsigned P_WIDTH       = 9,
  parameter int unsigned P_DECAY_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               evt,
  output logic [P_WIDTH-1:0] trace
);

  logic [P_WIDTH-1:0] trace_q, trace_d;
  logic               tick;

  if (P_DECAY_SHIFT == 0) begin : g_no_prescale
    assign tick = 1'b1;
  end else begin : g_prescale
    logic [P_DECAY_SHIFT-1:0] pre_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= pre_q + 1'b1;
    end
    assign tick = &pre_q;
  end

  always_comb begin
    trace_d = trace_q;
    if (evt)                          trace_d = P_WIDTH'(trace_max(P_WIDTH));
    else if (tick && trace_q != '0)   trace_d = trace_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trace_q <= '0;
    else        trace_q <= trace_d;
  end

  assign trace = trace_q;

endmodule

// File: rtl/odesa_sup_layer.sv
// ODESA supervised classification layer.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_event          : per-channel event pulses; any bit starts a classification when idle
//   i_label          : one-hot supervision label, latched with the starting event
//   i_endof_epochs   : freezes learning
//   o_tr             : concatenated channel traces, channel 0 in the LSBs
//   o_spike_out      : one-hot winner pulse; o_las pulses alongside it
//   o_gas            : pulses in a cycle where learning is applied
//   o_busy           : classification in progress
// Learning is compiled in only when ODESA_LEARN_EN is defined; otherwise weights and
// thresholds are fixed at their reset values.
module odesa_sup_layer
  import odesa_pkg::*;
#(
  parameter int unsigned P_IN          = 2,
  parameter int unsigned P_NEUR        = 4,
  parameter int unsigned P_WIDTH       = 9,
  parameter int unsigned P_DECAY_SHIFT = 0,
  parameter int unsigned P_ETA_SHIFT   = 3,
  parameter int unsigned P_TH_INIT     = 0,
  parameter int unsigned P_TH_STEP     = 16,
  parameter int unsigned P_W_INIT      = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [P_IN-1:0]           i_event,
  input  logic [P_NEUR-1:0]         i_label,
  input  logic                      i_endof_epochs,
  output logic [P_IN*P_WIDTH-1:0]   o_tr,
  output logic [P_NEUR-1:0]         o_spike_out,
  output logic                      o_las,
  output logic                      o_gas,
  output logic                      o_busy
);

  localparam int unsigned ScoreW = score_width(P_WIDTH, P_IN);
  localparam int unsigned IdxW   = (clog2(P_NEUR) > 0) ? clog2(P_NEUR) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(P_NEUR - 1);
`ifdef ODESA_LEARN_EN
  localparam bit LearnEn = 1'b1;
`else
  localparam bit LearnEn = 1'b0;
`endif

  state_e               state_q, state_d;
  logic                 start;
  logic [P_WIDTH-1:0]   trace   [P_IN];
  logic [P_WIDTH-1:0]   snap_q  [P_IN];
  logic [IdxW-1:0]      idx_q;
  logic [ScoreW-1:0]    score_q [P_NEUR];
  logic [ScoreW-1:0]    score_cur;
  logic [P_WIDTH-1:0]   weight  [P_NEUR][P_IN];
  logic [ScoreW-1:0]    thresh  [P_NEUR];
  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  logic [ScoreW-1:0]    win_score;
  logic [P_NEUR-1:0]    spike_q;
  logic                 las_q;
  logic                 gas;

  for (genvar c = 0; c < P_IN; c++) begin : g_trace
    odesa_trace #(
      .P_WIDTH       (P_WIDTH),
      .P_DECAY_SHIFT (P_DECAY_SHIFT)
    ) u_trace (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .evt   (i_event[c]),
      .trace (trace[c])
    );
    assign o_tr[c*P_WIDTH +: P_WIDTH] = trace[c];
  end

  assign start = (state_q == StIdle) && (|i_event);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = StCapture;
      StCapture: state_d = StScore;
      StScore:   if (idx_q == LastIdx) state_d = StSelect;
      StSelect:  state_d = LearnEn ? StLearn : StIdle;
      StLearn:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy      = (state_q != StIdle);
    o_gas       = gas;
    o_spike_out = spike_q;
    o_las       = las_q;
  end

  // Dot product of the neuron currently being scored.
  always_comb begin
    score_cur = '0;
    for (int c = 0; c < P_IN; c++) begin
      score_cur = score_cur + ScoreW'(weight[idx_q][c]) * ScoreW'(snap_q[c]);
    end
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_score = '0;
    for (int n = 0; n < P_NEUR; n++) begin
      if (score_q[n] >= thresh[n] && (!win_found || score_q[n] > win_score)) begin
        win_found = 1'b1;
        win_idx   = IdxW'(n);
        win_score = score_q[n];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < P_IN; c++)   snap_q[c]  <= '0;
      for (int n = 0; n < P_NEUR; n++) score_q[n] <= '0;
      idx_q   <= '0;
      spike_q <= '0;
      las_q   <= 1'b0;
    end else begin
      spike_q <= '0;
      las_q   <= 1'b0;
      if (state_q == StCapture) begin
        snap_q <= trace;
        idx_q  <= '0;
      end
      if (state_q == StScore) begin
        score_q[idx_q] <= score_cur;
        idx_q          <= idx_q + 1'b1;
      end
      if (state_q == StSelect && win_found) begin
        spike_q <= P_NEUR'(1) << win_idx;
        las_q   <= 1'b1;
      end
    end
  end

`ifdef ODESA_LEARN_EN
  logic [P_NEUR-1:0] label_q;
  logic              win_valid_q;
  logic [IdxW-1:0]   win_idx_q;
  logic [ScoreW-1:0] win_score_q;
  logic [IdxW-1:0]   k_idx;
  logic              learn;
  logic [ScoreW:0]   th_up;
  logic [ScoreW-1:0] th_dn;

  function automatic logic [P_WIDTH-1:0] nudge(input logic [P_WIDTH-1:0] w,
                                               input logic [P_WIDTH-1:0] x);
    logic signed [P_WIDTH:0] diff;
    diff = $signed({1'b0, x}) - $signed({1'b0, w});
    diff = diff >>> P_ETA_SHIFT;
    return P_WIDTH'($signed({1'b0, w}) + diff);
  endfunction

  // Multi-hot labels resolve to the lowest set bit.
  always_comb begin
    k_idx = '0;
    for (int n = P_NEUR - 1; n >= 0; n--) begin
      if (label_q[n]) k_idx = IdxW'(n);
    end
  end

  assign learn = (state_q == StLearn) && (|label_q) && !i_endof_epochs;
  assign gas   = learn;
  assign th_up = {1'b0, thresh[win_idx_q]} + (ScoreW + 1)'(P_TH_STEP);
  assign th_dn = (thresh[k_idx] >= ScoreW'(P_TH_STEP)) ? thresh[k_idx] - ScoreW'(P_TH_STEP) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      label_q     <= '0;
      win_valid_q <= 1'b0;
      win_idx_q   <= '0;
      win_score_q <= '0;
      for (int n = 0; n < P_NEUR; n++) begin
        thresh[n] <= ScoreW'(P_TH_INIT);
        for (int c = 0; c < P_IN; c++) weight[n][c] <= P_WIDTH'(P_W_INIT);
      end
    end else begin
      if (start) label_q <= i_label;
      if (state_q == StSelect) begin
        win_valid_q <= win_found;
        win_idx_q   <= win_idx;
        win_score_q <= win_score;
      end
      if (learn) begin
        for (int c = 0; c < P_IN; c++) weight[k_idx][c] <= nudge(weight[k_idx][c], snap_q[c]);
        if (!win_valid_q)              thresh[k_idx]     <= th_dn;
        else if (win_idx_q != k_idx)   thresh[win_idx_q] <= th_up[ScoreW] ? '1 : th_up[ScoreW-1:0];
        else                           thresh[k_idx]     <= win_score_q;
      end
    end
  end
`else
  logic [31:0] unused_cfg;
  logic        unused_learn;

  always_comb begin
    for (int n = 0; n < P_NEUR; n++) begin
      thresh[n] = ScoreW'(P_TH_INIT);
      for (int c = 0; c < P_IN; c++) weight[n][c] = P_WIDTH'(P_W_INIT);
    end
  end

  assign gas          = 1'b0;
  assign unused_cfg   = P_ETA_SHIFT ^ P_TH_STEP;
  assign unused_learn = ^{i_label, i_endof_epochs, win_score, unused_cfg};
`endif

endmodule

// File: tb/tb_odesa_sup_layer.sv
module tb_odesa_sup_layer;

`ifdef ODESA_LEARN_EN
  localparam bit LearnEn = 1'b1;
`else
  localparam bit LearnEn = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_event = '0;
  logic [3:0]  i_label = '0;
  logic        i_endof_epochs = 1'b0;
  logic [3:0]  no_label = '0;
  logic        no_eoe = 1'b0;

  logic [17:0] tr1, tr2;
  logic [3:0]  spk1, spk2;
  logic        las1, las2, gas1, gas2, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb1[$];
  logic [3:0] sb2[$];

  always #5 i_clk = ~i_clk;

  odesa_sup_layer u_dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_event        (i_event),
    .i_label        (i_label),
    .i_endof_epochs (i_endof_epochs),
    .o_tr           (tr1),
    .o_spike_out    (spk1),
    .o_las          (las1),
    .o_gas          (gas1),
    .o_busy         (busy1)
  );

  // Uniform weights 5 and a high threshold: one channel (2555) misses, two channels (5110) win.
  odesa_sup_layer #(
    .P_W_INIT  (5),
    .P_TH_INIT (3000)
  ) u_dut_hi (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_event        (i_event),
    .i_label        (no_label),
    .i_endof_epochs (no_eoe),
    .o_tr           (tr2),
    .o_spike_out    (spk2),
    .o_las          (las2),
    .o_gas          (gas2),
    .o_busy         (busy2)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tr1"}, 32'(tr1), 0);
    check({tag, "_tr2"}, 32'(tr2), 0);
    check({tag, "_spk"}, 32'({spk1, spk2}), 0);
    check({tag, "_pulses"}, 32'({las1, las2, gas1, gas2}), 0);
    check({tag, "_busy"}, 32'({busy1, busy2}), 0);
  endtask

  // One classification: expected winners go into the scoreboard when the event is
  // driven and are popped once the observation window closes.
  task automatic run_class(input string tag, input logic [1:0] ev, input logic [3:0] lbl,
                           input logic eoe, input logic [3:0] exp1, input logic [3:0] exp2,
                           input logic exp_gas);
    int         las1_n, las1_at, las2_n, las2_at, gas_n, stray;
    logic [3:0] got1, got2, want1, want2;
    las1_n = 0; las1_at = 0; las2_n = 0; las2_at = 0; gas_n = 0; stray = 0;
    got1 = '0; got2 = '0;
    sb1.push_back(exp1);
    sb2.push_back(exp2);
    i_event = ev; i_label = lbl; i_endof_epochs = eoe;
    tick();
    i_event = '0; i_label = '0;
    check({tag, "_busy_t1"}, 32'(busy1), 1);
    for (int cyc = 2; cyc <= 14; cyc++) begin
      tick();
      if (las1) begin las1_n++; las1_at = cyc; got1 = spk1; end
      else if (spk1 != '0) stray++;
      if (las2) begin las2_n++; las2_at = cyc; got2 = spk2; end
      else if (spk2 != '0) stray++;
      if (gas1) gas_n++;
      if (gas2) stray++;
    end
    i_endof_epochs = 1'b0;
    want1 = sb1.pop_front();
    want2 = sb2.pop_front();
    if (want1 != '0) begin
      check({tag, "_las_n"}, 32'(las1_n), 1);
      check({tag, "_las_at"}, 32'(las1_at), 7);
      check({tag, "_spike"}, 32'(got1), 32'(want1));
    end else begin
      check({tag, "_no_las"}, 32'(las1_n), 0);
    end
    if (want2 != '0) begin
      check({tag, "_hi_las_n"}, 32'(las2_n), 1);
      check({tag, "_hi_las_at"}, 32'(las2_at), 7);
      check({tag, "_hi_spike"}, 32'(got2), 32'(want2));
    end else begin
      check({tag, "_hi_no_las"}, 32'(las2_n), 0);
    end
    check({tag, "_gas_n"}, 32'(gas_n), 32'(exp_gas));
    check({tag, "_stray"}, 32'(stray), 0);
    check({tag, "_idle"}, 32'({busy1, busy2}), 0);
  endtask

  initial begin
    int las_n, las_at;
    logic [3:0] got;

    // Reset state
    #3;
    check_quiet("rst");
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // Trace load and decay
    i_event = 2'b01;
    tick();
    i_event = '0;
    check("tr_t1", 32'(tr1[8:0]), 511);
    check("tr_ch1_idle", 32'(tr1[17:9]), 0);
    check("tr_hi_t1", 32'(tr2[8:0]), 511);
    repeat (10) tick();
    check("tr_t11", 32'(tr1[8:0]), 501);
    repeat (500) tick();
    check("tr_t511", 32'(tr1[8:0]), 1);
    tick();
    check("tr_t512", 32'(tr1[8:0]), 0);
    repeat (8) tick();
    check("tr_t520", 32'(tr1[8:0]), 0);

    // Default classification, then learning sequence
    run_class("dflt", 2'b01, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
    run_class("learn", 2'b01, 4'b0010, 1'b0, 4'b0001, 4'b0000, LearnEn);
    run_class("post_learn", 2'b01, 4'b0000, 1'b0, LearnEn ? 4'b0010 : 4'b0001, 4'b0000, 1'b0);
    run_class("eoe", 2'b01, 4'b0001, 1'b1, LearnEn ? 4'b0010 : 4'b0001, 4'b0000, 1'b0);
    run_class("post_eoe", 2'b01, 4'b0000, 1'b0, LearnEn ? 4'b0010 : 4'b0001, 4'b0000, 1'b0);
    run_class("multihot", 2'b01, 4'b0110, 1'b0, LearnEn ? 4'b0010 : 4'b0001, 4'b0000, LearnEn);

    // Second event while busy: trace reloads, no second classification
    las_n = 0; las_at = 0; got = '0;
    i_event = 2'b01;
    tick();
    i_event = '0;
    tick(); tick();
    check("b2b_tr_t3", 32'(tr1[8:0]), 509);
    i_event = 2'b01;
    tick();
    i_event = '0;
    check("b2b_tr_reload", 32'(tr1[8:0]), 511);
    check("b2b_busy", 32'(busy1), 1);
    for (int cyc = 5; cyc <= 20; cyc++) begin
      tick();
      if (las1) begin las_n++; las_at = cyc; got = spk1; end
    end
    check("b2b_las_n", 32'(las_n), 1);
    check("b2b_las_at", 32'(las_at), 7);
    check("b2b_spike", 32'(got), LearnEn ? 32'd2 : 32'd1);

    // Asynchronous reset in the middle of scoring
    i_event = 2'b01;
    tick();
    i_event = '0;
    tick(); tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    tick(); tick();
    i_rst_n = 1'b1;
    las_n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (las1 || las2 || spk1 != '0) las_n++;
    end
    check("midrst_no_spike", 32'(las_n), 0);
    run_class("post_rst", 2'b01, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);

    // Simultaneous events on both channels
    run_class("both_ch", 2'b11, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/odesa_sup_layer.md
ODESA_SUP_LAYER -- requirements
Module: odesa_sup_layer

Interface
REQ-001 SHALL have parameter P_IN, default 2: number of input event channels (1..8).
REQ-002 SHALL have parameter P_NEUR, default 4: number of neurons and label bits (1..16).
REQ-003 SHALL have parameter P_WIDTH, default 9: trace and weight width in bits.
REQ-004 SHALL have parameter P_DECAY_SHIFT, default 0: trace decrements by 1 every 2^P_DECAY_SHIFT clocks.
REQ-005 SHALL have parameters P_ETA_SHIFT (default 3), P_TH_INIT (default 0), P_TH_STEP (default 16), P_W_INIT (default 0).
REQ-006 SHALL have ports: i_clk  in  1  sole clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: i_event  in  P_IN  per-channel event pulse; i_label  in  P_NEUR  one-hot supervision label, sampled with the event; i_endof_epochs  in  1  freezes learning.
REQ-008 SHALL have ports: o_tr  out  P_IN*P_WIDTH  concatenated traces, channel 0 in LSBs; o_spike_out  out  P_NEUR  one-hot winner pulse; o_las  out  1  local attention pulse; o_gas  out  1  global attention pulse; o_busy  out  1  classification in progress.

Function
REQ-009 Each channel trace SHALL load 2^P_WIDTH-1 in the cycle after its i_event bit is high, otherwise decrement per REQ-004, saturating at 0; traces update every cycle regardless of FSM state.
REQ-010 FSM states SHALL be IDLE, CAPTURE, SCORE, SELECT, LEARN.
REQ-011 IDLE->CAPTURE when any i_event bit is high; i_label latched in the same cycle; o_busy high from the next cycle until return to IDLE.
REQ-012 CAPTURE SHALL snapshot all traces (including the just-loaded maximum) for one cycle.
REQ-013 SCORE SHALL compute one neuron per cycle, P_NEUR cycles: score = sum over channels of weight*trace, width 2*P_WIDTH+clog2(P_IN), no truncation.
REQ-014 SELECT SHALL pick the highest score with score >= its neuron threshold; ties resolve to the lowest index.
REQ-015 With a winner, o_spike_out SHALL carry its one-hot and o_las SHALL be 1 for exactly one cycle, the cycle after SELECT (event cycle + P_NEUR + 3).
REQ-016 Without a winner, o_spike_out and o_las SHALL stay 0.
REQ-017 LEARN (one cycle) SHALL run only if latched label is non-zero and i_endof_epochs is 0; otherwise it is a no-op.
REQ-018 In LEARN the labelled neuron k SHALL update each weight w += (x - w) >>> P_ETA_SHIFT (signed difference, arithmetic shift) and o_gas SHALL pulse one cycle.
REQ-019 If a winner exists and differs from k, the winner threshold SHALL rise by P_TH_STEP, saturating at maximum; if no winner, threshold k SHALL fall by P_TH_STEP, saturating at 0; if winner == k, threshold k SHALL become its score.
REQ-020 Multi-hot i_label SHALL be resolved to its lowest set bit.
REQ-021 Events arriving while o_busy is high SHALL update traces but SHALL NOT start a classification.
REQ-022 Simultaneous events on several channels SHALL trigger one classification.

Reset
REQ-023 On i_rst_n low, asynchronously: traces 0, weights P_W_INIT, thresholds P_TH_INIT, FSM IDLE, all outputs 0.
REQ-024 Reset mid-classification SHALL abort with no spike, no learning, no partial weight write.

Configuration
REQ-025 With ODESA_LEARN_EN defined, REQ-017..REQ-020 SHALL apply.
REQ-026 Without ODESA_LEARN_EN, LEARN SHALL be skipped, weights and thresholds SHALL hold reset values, i_label and i_endof_epochs SHALL be ignored, o_gas tied 0.

Structure
REQ-027 Package odesa_pkg SHALL hold the FSM state enum, score-width and clog2 helper functions, and trace-max constant.
REQ-028 Sub-module odesa_trace SHALL implement one decaying channel trace, instantiated P_IN times.

Verification
REQ-029 Reset mid-run -> all outputs 0, o_tr=0, next event classified with initial weights.
REQ-030 Event on ch0 at cycle t, defaults -> o_tr[8:0]=511 at t+1, 501 at t+11, 0 from t+512 on.
REQ-031 Defaults, no label, event ch0 -> all scores 0 >= threshold 0, o_spike_out=4'b0001 and o_las=1 at t+7 only.
REQ-032 Learning: event ch0 with label 4'b0010 -> winner 0, neuron1 weight ch0 becomes 63, neuron0 threshold 16, o_gas pulse 1 cycle.
REQ-033 Second event 3 cycles after first -> trace reloads to 511, o_busy stays high, exactly one o_las pulse.
REQ-034 i_endof_epochs=1 with label, or macro undefined -> weights/thresholds unchanged, o_gas stays 0.
